// File: rtl/lieat_exu_wbarb_if.sv
// lieat_exu_wbarb_if -- writeback arbiter bus bundle.
// Carries the per-channel result buses (flattened, channel k at slice k),
// the registered writeback port, the long-result retire pulse and the
// forwarding lookup port.
//   slave  : arbiter view (consumes channel results, drives writeback)
//   master : environment view (drives channel results, consumes writeback)
interface lieat_exu_wbarb_if #(
  parameter int NCH        = 3,
  parameter int XLEN       = 32,
  parameter int RGIDX_SIZE = 5,
  parameter int CW         = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]            ch_i_valid;
  logic [NCH-1:0]            ch_i_ready;
  logic [NCH*XLEN-1:0]       ch_i_pc;
  logic [NCH-1:0]            ch_i_en;
  logic [NCH*RGIDX_SIZE-1:0] ch_i_rd;
  logic [NCH*XLEN-1:0]       ch_i_data;
  logic [NCH-1:0]            ch_i_long;

  logic                      wbck_o_valid;
  logic                      wbck_o_ready;
  logic [XLEN-1:0]           wbck_o_pc;
  logic [XLEN-1:0]           wbck_o_data;
  logic [RGIDX_SIZE-1:0]     wbck_o_rd;
  logic                      wbck_o_en;
  logic [CW-1:0]             wbck_o_ch;

  logic                      longi_wbck;
  logic [CW-1:0]             longi_wbck_ch;

  logic [RGIDX_SIZE-1:0]     fwd_rs1;
  logic [RGIDX_SIZE-1:0]     fwd_rs2;
  logic                      fwd_rs1_hit;
  logic                      fwd_rs2_hit;
  logic [XLEN-1:0]           fwd_data;

  modport slave (
    input  ch_i_valid, ch_i_pc, ch_i_en, ch_i_rd, ch_i_data, ch_i_long,
    input  wbck_o_ready, fwd_rs1, fwd_rs2,
    output ch_i_ready, wbck_o_valid, wbck_o_pc, wbck_o_data, wbck_o_rd,
    output wbck_o_en, wbck_o_ch, longi_wbck, longi_wbck_ch,
    output fwd_rs1_hit, fwd_rs2_hit, fwd_data
  );

  modport master (
    output ch_i_valid, ch_i_pc, ch_i_en, ch_i_rd, ch_i_data, ch_i_long,
    output wbck_o_ready, fwd_rs1, fwd_rs2,
    input  ch_i_ready, wbck_o_valid, wbck_o_pc, wbck_o_data, wbck_o_rd,
    input  wbck_o_en, wbck_o_ch, longi_wbck, longi_wbck_ch,
    input  fwd_rs1_hit, fwd_rs2_hit, fwd_data
  );
endinterface

// File: rtl/lieat_exu_wbarb.sv
// lieat_exu_wbarb -- execution-unit writeback arbiter.
// Picks one of NCH result channels per cycle (fixed priority or round-robin)
// into a single registered writeback slot, pulses longi_wbck when a
// long-latency result retires, and offers the slot contents for operand
// forwarding.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   wb   : lieat_exu_wbarb_if.slave bundle (channel inputs, writeback,
//          long-result pulse, forwarding lookup)
module lieat_exu_wbarb #(
  parameter int NCH        = 3,
  parameter int XLEN       = 32,
  parameter int RGIDX_SIZE = 5,
  parameter int ARB_MODE   = 0
) (
  input  logic               clk,
  input  logic               rstn,
  lieat_exu_wbarb_if.slave   wb
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  handshake_s;
  logic                  can_grant_s;
  logic                  found_s;
  logic                  grant_s;
  logic [NCH-1:0]        gnt_oh_s;
  logic [CW-1:0]         gnt_idx_s;
  logic [CW-1:0]         rr_ptr_r;
  logic                  long_r;
  logic [XLEN-1:0]       sel_pc_s;
  logic [XLEN-1:0]       sel_data_s;
  logic [RGIDX_SIZE-1:0] sel_rd_s;
  logic                  sel_en_s;
  logic                  sel_long_s;
  int                    idx_s;

  assign handshake_s = wb.wbck_o_valid & wb.wbck_o_ready;
  // The slot may accept a new result when empty or emptying this cycle.
  assign can_grant_s = ~wb.wbck_o_valid | wb.wbck_o_ready;

  // Arbitration: first valid channel starting at 0 (fixed) or at the RR pointer.
  always_comb begin
    found_s   = 1'b0;
    gnt_oh_s  = '0;
    gnt_idx_s = '0;
    idx_s     = 0;
    for (int i = 0; i < NCH; i++) begin
      if (ARB_MODE == 1) begin
        idx_s = (int'(rr_ptr_r) + i) % NCH;
      end else begin
        idx_s = i;
      end
      if (!found_s && wb.ch_i_valid[idx_s]) begin
        found_s         = 1'b1;
        gnt_idx_s       = CW'(idx_s);
        gnt_oh_s[idx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_s       = found_s & can_grant_s;
  assign wb.ch_i_ready = can_grant_s ? gnt_oh_s : {NCH{1'b0}};

  // One-hot mux of the granted channel's fields.
  always_comb begin
    sel_pc_s   = '0;
    sel_data_s = '0;
    sel_rd_s   = '0;
    sel_en_s   = 1'b0;
    sel_long_s = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_oh_s[k]) begin
        sel_pc_s   = wb.ch_i_pc[k*XLEN +: XLEN];
        sel_data_s = wb.ch_i_data[k*XLEN +: XLEN];
        sel_rd_s   = wb.ch_i_rd[k*RGIDX_SIZE +: RGIDX_SIZE];
        sel_en_s   = wb.ch_i_en[k];
        sel_long_s = wb.ch_i_long[k];
      end else begin
        sel_en_s = sel_en_s;
      end
    end
  end

  // Writeback slot: load on grant, empty on a drain without refill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb.wbck_o_valid <= 1'b0;
      wb.wbck_o_pc    <= '0;
      wb.wbck_o_data  <= '0;
      wb.wbck_o_rd    <= '0;
      wb.wbck_o_en    <= 1'b0;
      wb.wbck_o_ch    <= '0;
      long_r          <= 1'b0;
    end else if (grant_s) begin
      wb.wbck_o_valid <= 1'b1;
      wb.wbck_o_pc    <= sel_pc_s;
      wb.wbck_o_data  <= sel_data_s;
      wb.wbck_o_rd    <= sel_rd_s;
      wb.wbck_o_en    <= sel_en_s;
      wb.wbck_o_ch    <= gnt_idx_s;
      long_r          <= sel_long_s;
    end else if (handshake_s) begin
      wb.wbck_o_valid <= 1'b0;
    end else begin
      wb.wbck_o_valid <= wb.wbck_o_valid;
    end
  end

  // Round-robin pointer: moves just past the winner on every grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      if (gnt_idx_s == CW'(NCH - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= gnt_idx_s + CW'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign wb.longi_wbck    = handshake_s & long_r;
  assign wb.longi_wbck_ch = wb.wbck_o_ch;

  // x0 never forwards, even when written back with en=1.
  assign wb.fwd_rs1_hit = wb.wbck_o_valid & wb.wbck_o_en & (|wb.wbck_o_rd)
                        & (wb.wbck_o_rd == wb.fwd_rs1);
  assign wb.fwd_rs2_hit = wb.wbck_o_valid & wb.wbck_o_en & (|wb.wbck_o_rd)
                        & (wb.wbck_o_rd == wb.fwd_rs2);
  assign wb.fwd_data    = wb.wbck_o_data;

endmodule

// File: tb/tb_lieat_exu_wbarb.sv
// tb_lieat_exu_wbarb -- scoreboard bench for lieat_exu_wbarb.
// Two instances share one stimulus: dut0 in fixed-priority mode, dut1 in
// round-robin mode. Stimulus pushes expected writebacks into per-DUT queues;
// negedge monitors pop and compare on every writeback handshake.
module tb_lieat_exu_wbarb;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
    logic        lng;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [2:0]  vld;
  logic [2:0]  en_v;
  logic [2:0]  lng_v;
  logic [95:0] pc_v;
  logic [95:0] data_v;
  logic [14:0] rd_v;
  logic        rdy;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int   n_tests;
  int   n_fail;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  lieat_exu_wbarb_if #(.NCH(3), .XLEN(32), .RGIDX_SIZE(5), .CW(2)) if0 ();
  lieat_exu_wbarb_if #(.NCH(3), .XLEN(32), .RGIDX_SIZE(5), .CW(2)) if1 ();

  assign if0.ch_i_valid   = vld;
  assign if0.ch_i_pc      = pc_v;
  assign if0.ch_i_en      = en_v;
  assign if0.ch_i_rd      = rd_v;
  assign if0.ch_i_data    = data_v;
  assign if0.ch_i_long    = lng_v;
  assign if0.wbck_o_ready = rdy;
  assign if0.fwd_rs1      = rs1;
  assign if0.fwd_rs2      = rs2;

  assign if1.ch_i_valid   = vld;
  assign if1.ch_i_pc      = pc_v;
  assign if1.ch_i_en      = en_v;
  assign if1.ch_i_rd      = rd_v;
  assign if1.ch_i_data    = data_v;
  assign if1.ch_i_long    = lng_v;
  assign if1.wbck_o_ready = rdy;
  assign if1.fwd_rs1      = rs1;
  assign if1.fwd_rs2      = rs2;

  lieat_exu_wbarb #(.NCH(3), .XLEN(32), .RGIDX_SIZE(5), .ARB_MODE(0)) dut0 (
    .clk(clk), .rstn(rstn), .wb(if0.slave)
  );
  lieat_exu_wbarb #(.NCH(3), .XLEN(32), .RGIDX_SIZE(5), .ARB_MODE(1)) dut1 (
    .clk(clk), .rstn(rstn), .wb(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setch(input int k, input logic [31:0] d, input logic [4:0] r,
                       input logic e, input logic l);
    pc_v[k*32 +: 32]  = 32'h0000_1000 + 32'(k * 4);
    data_v[k*32 +: 32] = d;
    rd_v[k*5 +: 5]    = r;
    en_v[k]           = e;
    lng_v[k]          = l;
  endtask

  function automatic exp_t mk(input int k);
    exp_t e;
    e.ch   = 2'(k);
    e.pc   = pc_v[k*32 +: 32];
    e.data = data_v[k*32 +: 32];
    e.rd   = rd_v[k*5 +: 5];
    e.en   = en_v[k];
    e.lng  = lng_v[k];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the fixed-priority instance.
  always @(negedge clk) begin
    if (if0.wbck_o_valid && if0.wbck_o_ready) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb0_unexpected: got ch %0d expected no writeback", if0.wbck_o_ch);
      end else begin
        e0 = q0.pop_front();
        chk("wb0_ch",    64'(if0.wbck_o_ch),     64'(e0.ch));
        chk("wb0_pc",    64'(if0.wbck_o_pc),     64'(e0.pc));
        chk("wb0_data",  64'(if0.wbck_o_data),   64'(e0.data));
        chk("wb0_rd",    64'(if0.wbck_o_rd),     64'(e0.rd));
        chk("wb0_en",    64'(if0.wbck_o_en),     64'(e0.en));
        chk("wb0_longi", 64'(if0.longi_wbck),    64'(e0.lng));
        chk("wb0_lch",   64'(if0.longi_wbck_ch), 64'(e0.ch));
      end
    end
  end

  // Monitor for the round-robin instance.
  always @(negedge clk) begin
    if (if1.wbck_o_valid && if1.wbck_o_ready) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb1_unexpected: got ch %0d expected no writeback", if1.wbck_o_ch);
      end else begin
        e1 = q1.pop_front();
        chk("wb1_ch",    64'(if1.wbck_o_ch),     64'(e1.ch));
        chk("wb1_pc",    64'(if1.wbck_o_pc),     64'(e1.pc));
        chk("wb1_data",  64'(if1.wbck_o_data),   64'(e1.data));
        chk("wb1_rd",    64'(if1.wbck_o_rd),     64'(e1.rd));
        chk("wb1_en",    64'(if1.wbck_o_en),     64'(e1.en));
        chk("wb1_longi", 64'(if1.longi_wbck),    64'(e1.lng));
        chk("wb1_lch",   64'(if1.longi_wbck_ch), 64'(e1.ch));
      end
    end
  end

  initial begin
    logic [2:0] rr_exp;
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    vld     = 3'b000;
    en_v    = 3'b000;
    lng_v   = 3'b000;
    pc_v    = 96'h0;
    data_v  = 96'h0;
    rd_v    = 15'h0;
    rdy     = 1'b0;
    rs1     = 5'd0;
    rs2     = 5'd0;

    // Reset state.
    @(negedge clk);
    chk("rst_valid0", 64'(if0.wbck_o_valid), 64'd0);
    chk("rst_valid1", 64'(if1.wbck_o_valid), 64'd0);
    chk("rst_fields0", {if0.wbck_o_pc, if0.wbck_o_data}, 64'd0);
    chk("rst_misc0", 64'({if0.wbck_o_rd, if0.wbck_o_en, if0.wbck_o_ch}), 64'd0);
    chk("rst_misc1", 64'({if1.wbck_o_rd, if1.wbck_o_en, if1.wbck_o_ch}), 64'd0);
    chk("rst_longi", 64'({if0.longi_wbck, if1.longi_wbck}), 64'd0);
    chk("rst_hits", 64'({if0.fwd_rs1_hit, if0.fwd_rs2_hit, if1.fwd_rs1_hit, if1.fwd_rs2_hit}), 64'd0);
    tick();
    rstn = 1'b1;

    // All channels valid for six cycles, ready high.
    for (int k = 0; k < 3; k++) setch(k, 32'h0000_00A0 + 32'(k), 5'(k + 1), 1'b1, 1'b0);
    vld = 3'b111;
    rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rr_exp = 3'b001 << (c % 3);
      chk("fixed_ready", 64'(if0.ch_i_ready), 64'(3'b001));
      chk("rr_ready", 64'(if1.ch_i_ready), 64'(rr_exp));
      q0.push_back(mk(0));
      q1.push_back(mk(c % 3));
      tick();
    end
    vld = 3'b000;
    @(negedge clk);
    tick();

    // Stall with slot full, then drain plus same-cycle refill from ch1.
    setch(0, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0);
    setch(1, 32'h1111_0001, 5'd9, 1'b1, 1'b0);
    vld = 3'b001;
    rdy = 1'b0;
    @(negedge clk);
    chk("stall_grant0", 64'(if0.ch_i_ready), 64'(3'b001));
    chk("stall_grant1", 64'(if1.ch_i_ready), 64'(3'b001));
    q0.push_back(mk(0));
    q1.push_back(mk(0));
    tick();
    vld = 3'b010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_valid", 64'({if0.wbck_o_valid, if1.wbck_o_valid}), 64'(2'b11));
      chk("stall_data", {if0.wbck_o_data, if1.wbck_o_data}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      chk("stall_rd", 64'({if0.wbck_o_rd, if1.wbck_o_rd}), 64'({5'd5, 5'd5}));
      chk("stall_ready", 64'({if0.ch_i_ready, if1.ch_i_ready}), 64'd0);
      tick();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("refill_ready0", 64'(if0.ch_i_ready), 64'(3'b010));
    chk("refill_ready1", 64'(if1.ch_i_ready), 64'(3'b010));
    q0.push_back(mk(1));
    q1.push_back(mk(1));
    tick();
    vld = 3'b000;
    @(negedge clk);
    tick();

    // Long result on ch2 with forwarding lookup.
    setch(2, 32'hCAFE_0002, 5'd7, 1'b1, 1'b1);
    rs1 = 5'd7;
    rs2 = 5'd0;
    rdy = 1'b0;
    vld = 3'b100;
    @(negedge clk);
    chk("long_ready", 64'({if0.ch_i_ready, if1.ch_i_ready}), 64'({3'b100, 3'b100}));
    q0.push_back(mk(2));
    q1.push_back(mk(2));
    tick();
    vld = 3'b000;
    @(negedge clk);
    chk("fwd_rs1_hit", 64'({if0.fwd_rs1_hit, if1.fwd_rs1_hit}), 64'(2'b11));
    chk("fwd_rs2_hit", 64'({if0.fwd_rs2_hit, if1.fwd_rs2_hit}), 64'd0);
    chk("fwd_data", {if0.fwd_data, if1.fwd_data}, {32'hCAFE_0002, 32'hCAFE_0002});
    chk("longi_stalled", 64'({if0.longi_wbck, if1.longi_wbck}), 64'd0);
    tick();
    rdy = 1'b1;
    @(negedge clk);
    chk("fwd_hit_drain", 64'({if0.fwd_rs1_hit, if1.fwd_rs1_hit}), 64'(2'b11));
    tick();
    @(negedge clk);
    chk("longi_after", 64'({if0.longi_wbck, if1.longi_wbck}), 64'd0);
    chk("fwd_hit_empty", 64'({if0.fwd_rs1_hit, if1.fwd_rs1_hit}), 64'd0);
    tick();

    // rd=0 writes back but never forwards.
    setch(0, 32'h0000_5555, 5'd0, 1'b1, 1'b0);
    rs1 = 5'd0;
    vld = 3'b001;
    @(negedge clk);
    chk("x0_ready", 64'({if0.ch_i_ready, if1.ch_i_ready}), 64'({3'b001, 3'b001}));
    q0.push_back(mk(0));
    q1.push_back(mk(0));
    tick();
    vld = 3'b000;
    @(negedge clk);
    chk("x0_valid", 64'({if0.wbck_o_valid, if1.wbck_o_valid}), 64'(2'b11));
    chk("x0_nohit", 64'({if0.fwd_rs1_hit, if1.fwd_rs1_hit}), 64'd0);
    tick();

    // Reset mid-stall with the RR pointer at 2; the slot contents are discarded.
    vld = 3'b010;
    rdy = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", 64'({if0.ch_i_ready, if1.ch_i_ready}), 64'({3'b010, 3'b010}));
    tick();
    vld = 3'b000;
    @(negedge clk);
    chk("pre_rst_full", 64'({if0.wbck_o_valid, if1.wbck_o_valid}), 64'(2'b11));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'({if0.wbck_o_valid, if1.wbck_o_valid}), 64'd0);
    chk("async_rst_ch", 64'({if0.wbck_o_ch, if1.wbck_o_ch}), 64'd0);
    vld = 3'b111;
    rdy = 1'b1;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_fixed", 64'(if0.ch_i_ready), 64'(3'b001));
    chk("post_rst_rr", 64'(if1.ch_i_ready), 64'(3'b001));
    q0.push_back(mk(0));
    q1.push_back(mk(0));
    tick();
    vld = 3'b000;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
